fifo_reader_ctrl: RTL and testbench

//  Read-side controller for a QoS FIFO instance: drains a source FIFO (src_*) whenever it holds data,
//  re-times each word through its one-cycle read latency and pushes it into a downstream FIFO (dst_*).

---
 rtl/fifo_reader_ctrl_pkg.sv | 15 +
 rtl/fifo_reader_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_reader_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controller.
// Holds the controller state encoding and the default word and counter widths.
package fifo_reader_ctrl_pkg;

    localparam int DEFAULT_BW    = 4;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

endpackage : fifo_reader_ctrl_pkg

// File: rtl/fifo_reader_ctrl.sv
// Drains a source FIFO into a destination FIFO, absorbing the one-cycle source read
// latency, honouring destination back-pressure and latching a sticky error on overflow.
module fifo_reader_ctrl
    import fifo_reader_ctrl_pkg::*;
#(
    parameter int BW    = DEFAULT_BW,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             reader_en,
    input  logic             src_empty,
    input  logic [BW-1:0]    src_data_out,
    input  logic             src_error,
    output logic             src_rd,
    input  logic             dst_full,
    input  logic             dst_almost_full,
    output logic             dst_wr,
    output logic [BW-1:0]    dst_data_in,
    output logic [CNT_W-1:0] word_count,
    output logic             reader_idle,
    output logic             error_output
);

    state_e           state_q, state_d;
    logic             in_flight_q, in_flight_d;
    logic             dst_wr_q, dst_wr_d;
    logic [BW-1:0]    dst_data_q, dst_data_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             error_q, error_d;
    logic             error_event;

    // An in-flight word that meets a full destination cannot be parked anywhere, so it is lost.
    assign error_event = (in_flight_q & dst_full) | src_error;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (error_event) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (reader_en) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!reader_en) begin
                        state_d = ST_IDLE;
                    end else if (dst_almost_full) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!reader_en) begin
                        state_d = ST_IDLE;
                    end else if (!dst_almost_full) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_ERROR;
                end
            endcase
        end
    end

    // Reads are also suppressed in the cycle an error is detected so no further word is lost.
    always_comb begin
        src_rd      = (state_q == ST_RUN) & reader_en & ~src_empty & ~dst_almost_full
                    & ~error_event;
        reader_idle = (state_q == ST_IDLE) & ~in_flight_q & ~dst_wr_q;
    end

    always_comb begin
        in_flight_d  = src_rd;
        dst_wr_d     = in_flight_q & ~error_event & (state_q != ST_ERROR);
        dst_data_d   = dst_wr_d ? src_data_out : dst_data_q;
        word_count_d = dst_wr_q ? word_count_q + CNT_W'(1) : word_count_q;
        error_d      = error_q | error_event;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            in_flight_q  <= 1'b0;
            dst_wr_q     <= 1'b0;
            dst_data_q   <= '0;
            word_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            in_flight_q  <= in_flight_d;
            dst_wr_q     <= dst_wr_d;
            dst_data_q   <= dst_data_d;
            word_count_q <= word_count_d;
            error_q      <= error_d;
        end
    end

    assign dst_wr       = dst_wr_q;
    assign dst_data_in  = dst_data_q;
    assign word_count   = word_count_q;
    assign error_output = error_q;

endmodule : fifo_reader_ctrl

// File: tb/tb_fifo_reader_ctrl.sv
// Directed bench for fifo_reader_ctrl with behavioural source and destination FIFOs.
// A second instance with a 3-bit counter shares all inputs to observe counter wrap.
module tb_fifo_reader_ctrl;
    import fifo_reader_ctrl_pkg::*;

    localparam int BW    = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             reader_en = 1'b0;
    logic             src_empty = 1'b1;
    logic [BW-1:0]    src_data_out = '0;
    logic             src_error = 1'b0;
    logic             src_rd;
    logic             dst_full = 1'b0;
    logic             dst_almost_full = 1'b0;
    logic             dst_wr;
    logic [BW-1:0]    dst_data_in;
    logic [CNT_W-1:0] word_count;
    logic             reader_idle;
    logic             error_output;

    logic             w_src_rd;
    logic             w_dst_wr;
    logic [BW-1:0]    w_dst_data_in;
    logic [2:0]       wrap_count;
    logic             w_reader_idle;
    logic             w_error_output;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [BW-1:0] src_mem[$];
    logic [BW-1:0] dst_got[$];
    int            rd_cycles[$];
    int            wr_cycles[$];

    fifo_reader_ctrl #(.BW(BW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_L(reset_L), .reader_en(reader_en), .src_empty(src_empty),
        .src_data_out(src_data_out), .src_error(src_error), .src_rd(src_rd),
        .dst_full(dst_full), .dst_almost_full(dst_almost_full), .dst_wr(dst_wr),
        .dst_data_in(dst_data_in), .word_count(word_count), .reader_idle(reader_idle),
        .error_output(error_output)
    );

    fifo_reader_ctrl #(.BW(BW), .CNT_W(3)) dut_wrap (
        .clk(clk), .reset_L(reset_L), .reader_en(reader_en), .src_empty(src_empty),
        .src_data_out(src_data_out), .src_error(src_error), .src_rd(w_src_rd),
        .dst_full(dst_full), .dst_almost_full(dst_almost_full), .dst_wr(w_dst_wr),
        .dst_data_in(w_dst_data_in), .word_count(wrap_count), .reader_idle(w_reader_idle),
        .error_output(w_error_output)
    );

    always #5 clk = ~clk;

    // Source FIFO with one-cycle read latency plus a destination capture log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_rd) begin
            rd_cycles.push_back(cyc);
            if (src_mem.size() > 0) begin
                src_data_out <= src_mem.pop_front();
            end
        end
        if (dst_wr) begin
            dst_got.push_back(dst_data_in);
            wr_cycles.push_back(cyc);
        end
        src_empty <= (src_mem.size() == 0);
    end

    task automatic do_reset();
        reader_en = 1'b0;
        src_error = 1'b0;
        dst_full = 1'b0;
        dst_almost_full = 1'b0;
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        src_mem.delete();
        dst_got.delete();
        rd_cycles.delete();
        wr_cycles.delete();
        reset_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_words(input int n);
        for (int i = 1; i <= n; i++) begin
            src_mem.push_back(BW'(i));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        reader_en = 1'b1;
        for (int i = 1; i <= 3; i++) src_mem.push_back(BW'(i));
        repeat (2) @(negedge clk);
        tests_run++;
        if (src_rd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_src_rd: got %b expected 0", src_rd);
        end
        tests_run++;
        if (dst_wr !== 1'b0 || dst_data_in !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dst: got wr=%b data=%h expected wr=0 data=0", dst_wr, dst_data_in);
        end
        tests_run++;
        if (word_count !== 8'd0 || error_output !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count_err: got count=%0d err=%b expected 0 0", word_count, error_output);
        end
        tests_run++;
        if (reader_idle !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got %b expected 1", reader_idle);
        end
    endtask

    task automatic test_burst();
        do_reset();
        load_words(5);
        reader_en = 1'b1;
        repeat (12) @(negedge clk);
        reader_en = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (dst_got.size() != 5) begin
            tests_failed++;
            $display("[TB] FAIL burst_size: got %0d words expected 5", dst_got.size());
        end
        for (int i = 0; i < 5 && i < dst_got.size(); i++) begin
            tests_run++;
            if (dst_got[i] !== BW'(i + 1)) begin
                tests_failed++;
                $display("[TB] FAIL burst_data[%0d]: got %h expected %h", i, dst_got[i], BW'(i + 1));
            end
        end
        tests_run++;
        if (rd_cycles.size() < 1 || wr_cycles.size() < 1 || wr_cycles[0] - rd_cycles[0] != 2) begin
            tests_failed++;
            $display("[TB] FAIL burst_latency: got rd=%0d wr=%0d expected wr-rd=2",
                     rd_cycles.size(), wr_cycles.size());
        end
        tests_run++;
        if (wr_cycles.size() < 5 || wr_cycles[4] - wr_cycles[0] != 4) begin
            tests_failed++;
            $display("[TB] FAIL burst_back_to_back: got %0d writes, not in 5 consecutive cycles",
                     wr_cycles.size());
        end
        tests_run++;
        if (word_count !== 8'd5) begin
            tests_failed++;
            $display("[TB] FAIL burst_count: got %0d expected 5", word_count);
        end
        tests_run++;
        if (reader_idle !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL burst_idle: got %b expected 1", reader_idle);
        end
    endtask

    task automatic test_back_pressure();
        int n;
        do_reset();
        load_words(8);
        reader_en = 1'b1;
        n = 0;
        while (rd_cycles.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 50) begin
            tests_failed++;
            $display("[TB] FAIL bp_timeout: got %0d reads expected 3", rd_cycles.size());
        end
        dst_almost_full = 1'b1;
        #1;
        tests_run++;
        if (src_rd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_same_cycle: got src_rd=%b expected 0", src_rd);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (dst_got.size() != 3 || rd_cycles.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: got writes=%0d reads=%0d expected 3 3", dst_got.size(), rd_cycles.size());
        end
        tests_run++;
        if (dut.state_q !== ST_PAUSE) begin
            tests_failed++;
            $display("[TB] FAIL bp_state: got %0d expected %0d", dut.state_q, ST_PAUSE);
        end
        dst_almost_full = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (dst_got.size() != 8) begin
            tests_failed++;
            $display("[TB] FAIL bp_resume_size: got %0d expected 8", dst_got.size());
        end
        for (int i = 0; i < 8 && i < dst_got.size(); i++) begin
            tests_run++;
            if (dst_got[i] !== BW'(i + 1)) begin
                tests_failed++;
                $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, dst_got[i], BW'(i + 1));
            end
        end
        reader_en = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        load_words(4);
        reader_en = 1'b1;
        n = 0;
        while (rd_cycles.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        dst_full = 1'b1;
        @(negedge clk);
        tests_run++;
        if (error_output !== 1'b1 || dst_wr !== 1'b0 || dst_got.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_detect: got err=%b wr=%b writes=%0d expected 1 0 0",
                     error_output, dst_wr, dst_got.size());
        end
        dst_full = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (rd_cycles.size() != 1 || dst_got.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_no_reads: got reads=%0d writes=%0d expected 1 0",
                     rd_cycles.size(), dst_got.size());
        end
        tests_run++;
        if (error_output !== 1'b1 || reader_idle !== 1'b0 || word_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_sticky: got err=%b idle=%b count=%0d expected 1 0 0",
                     error_output, reader_idle, word_count);
        end
    endtask

    task automatic test_src_error();
        do_reset();
        reader_en = 1'b1;
        src_error = 1'b1;
        @(negedge clk);
        src_error = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (error_output !== 1'b1 || dut.state_q !== ST_ERROR) begin
            tests_failed++;
            $display("[TB] FAIL src_error: got err=%b state=%0d expected 1 %0d",
                     error_output, dut.state_q, ST_ERROR);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        load_words(9);
        reader_en = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (word_count !== 8'd9) begin
            tests_failed++;
            $display("[TB] FAIL wrap_wide_count: got %0d expected 9", word_count);
        end
        tests_run++;
        if (wrap_count !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_count: got %0d expected 1", wrap_count);
        end
        reader_en = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n;
        do_reset();
        load_words(5);
        reader_en = 1'b1;
        n = 0;
        while (rd_cycles.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        reader_en = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (rd_cycles.size() != 2 || dst_got.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL drop_count: got reads=%0d writes=%0d expected 2 2",
                     rd_cycles.size(), dst_got.size());
        end
        tests_run++;
        if (dst_got.size() < 2 || dst_got[0] !== 4'h1 || dst_got[1] !== 4'h2) begin
            tests_failed++;
            $display("[TB] FAIL drop_data: got %0d words, expected 1 then 2", dst_got.size());
        end
        tests_run++;
        if (reader_idle !== 1'b1 || dut.state_q !== ST_IDLE || word_count !== 8'd2) begin
            tests_failed++;
            $display("[TB] FAIL drop_idle: got idle=%b state=%0d count=%0d expected 1 %0d 2",
                     reader_idle, dut.state_q, word_count, ST_IDLE);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_burst();
        test_back_pressure();
        test_overflow();
        test_src_error();
        test_wrap();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fifo_reader_ctrl
